// File: rtl/transmissor_angulo_distancia_if.sv
// Handshake and data bundle between the sonar control unit and the serial reporting stage.
// The master modport is the control side and the slave modport is the transmitter.
interface transmissor_angulo_distancia_if;
  logic        partida;
  logic [11:0] angulo;
  logic [11:0] distancia;
  logic        saida_serial;
  logic        ocupado;
  logic        pronto;
  logic [3:0]  db_estado;

  modport master (
    output partida, angulo, distancia,
    input  saida_serial, ocupado, pronto, db_estado
  );

  modport slave (
    input  partida, angulo, distancia,
    output saida_serial, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/transmissor_angulo_distancia.sv
// UART reporter for the sonar: sends "aaa,ddd#" (7E2, LSB first) from captured BCD angle/distance.
// The last character exits straight to the final state so pronto starts on the edge where the last stop bit ends.
module transmissor_angulo_distancia #(
  parameter int BAUD_DIV = 434
) (
  input logic clock,
  input logic reset,
  transmissor_angulo_distancia_if.slave bus
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [3:0] {
    st_inicial    = 4'd0,
    st_preparacao = 4'd1,
    st_carrega    = 4'd2,
    st_transmite  = 4'd3,
    st_proximo    = 4'd4,
    st_final      = 4'd5
  } state_t;

  state_t           state;
  logic [2:0]       idx;
  logic [11:0]      ang_cap;
  logic [11:0]      dist_cap;
  logic [10:0]      shift;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic             tx_line;
  logic             busy_q;
  logic             pronto_q;

  // Digits are mapped as 0x30 + nibble, so non-BCD nibbles land on ':'..'?'.
  function automatic logic [6:0] digit_char(input logic [3:0] nib);
    return {3'b011, nib};
  endfunction

  function automatic logic [6:0] char_at(input logic [2:0] i, input logic [11:0] a,
                                         input logic [11:0] d);
    logic [6:0] c;
    case (i)
      3'd0:    c = digit_char(a[11:8]);
      3'd1:    c = digit_char(a[7:4]);
      3'd2:    c = digit_char(a[3:0]);
      3'd3:    c = 7'h2C;
      3'd4:    c = digit_char(d[11:8]);
      3'd5:    c = digit_char(d[7:4]);
      3'd6:    c = digit_char(d[3:0]);
      default: c = 7'h23;
    endcase
    return c;
  endfunction

  // Bit 0 is sent first: start, d0..d6, even parity, two stop bits.
  function automatic logic [10:0] frame_word(input logic [6:0] c);
    return {2'b11, ^c, c, 1'b0};
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= st_inicial;
      idx      <= '0;
      ang_cap  <= '0;
      dist_cap <= '0;
      shift    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_line  <= 1'b1;
      busy_q   <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (state)
        st_inicial: begin
          tx_line <= 1'b1;
          if (bus.partida) begin
            state  <= st_preparacao;
            busy_q <= 1'b1;
          end
        end
        st_preparacao: begin
          ang_cap  <= bus.angulo;
          dist_cap <= bus.distancia;
          idx      <= '0;
          state    <= st_carrega;
        end
        st_carrega: begin
          shift    <= frame_word(char_at(idx, ang_cap, dist_cap));
          tx_line  <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          state    <= st_transmite;
        end
        st_transmite: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd10) begin
              tx_line <= 1'b1;
              if (idx == 3'd7) begin
                state    <= st_final;
                pronto_q <= 1'b1;
                busy_q   <= 1'b0;
              end else begin
                state <= st_proximo;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              shift   <= {1'b1, shift[10:1]};
              tx_line <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        st_proximo: begin
          idx   <= idx + 3'd1;
          state <= st_carrega;
        end
        st_final: begin
          state <= st_inicial;
        end
        default: begin
          state   <= st_inicial;
          busy_q  <= 1'b0;
          tx_line <= 1'b1;
        end
      endcase
    end
  end

  assign bus.saida_serial = tx_line;
  assign bus.ocupado      = busy_q;
  assign bus.pronto       = pronto_q;
  assign bus.db_estado    = state;

endmodule
